// File: rtl/seq_match_monitor_if.sv
// Position readout channel of seq_match_monitor: the producer presents the
// oldest queued match position; the consumer pops it by holding pos_ready.
interface seq_match_monitor_if #(
  parameter int POS_W = 16
);
  // pos_data is valid whenever pos_valid is high and must not change until
  // the cycle pos_valid & pos_ready are both high (one entry moves per such cycle).
  logic             pos_valid;
  logic [POS_W-1:0] pos_data;
  logic             pos_ready;

  modport master (output pos_valid, output pos_data, input pos_ready);
  modport slave  (input pos_valid, input pos_data, output pos_ready);
endinterface

// File: rtl/seq_match_monitor.sv
// Counts pattern-detector matches, flags a programmable threshold and queues
// the serial bit position of each match in a small FIFO.
module seq_match_monitor #(
  parameter int CNT_W      = 8,
  parameter int POS_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             det_in,
  input  logic             clear,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] match_count,
  output logic             thresh_hit,
  output logic             overflow,
  output logic             state_dbg,
  seq_match_monitor_if.master pos_if
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  typedef enum logic {ARMED = 1'b0, HIT = 1'b1} state_t;

  state_t           state;
  logic [POS_W-1:0] bit_pos;
  logic [POS_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             match_ev;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;

  assign match_ev = bit_valid & det_in;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && pos_if.pos_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push     = match_ev && (!full || pop);
  assign cnt_sat  = &match_count;
  assign cnt_inc  = match_count + CNT_W'(1);

  assign pos_if.pos_valid = !empty;
  assign pos_if.pos_data  = mem[rd_ptr[AW-1:0]];
  assign state_dbg        = (state == HIT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= ARMED;
      thresh_hit  <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
      bit_pos     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (bit_valid) bit_pos <= bit_pos + POS_W'(1);
      if (match_ev && !cnt_sat) match_count <= cnt_inc;
      if (match_ev && full && !pop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        ARMED: begin
          // Only an exact hit on an actual increment arms the flag.
          if (match_ev && !cnt_sat && (thresh != '0) && (cnt_inc == thresh)) begin
            state      <= HIT;
            thresh_hit <= 1'b1;
          end
        end
        HIT: begin
          state      <= HIT;
          thresh_hit <= 1'b1;
        end
        default: begin
          state      <= ARMED;
          thresh_hit <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear && push) mem[wr_ptr[AW-1:0]] <= bit_pos;
  end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed bench for seq_match_monitor: a 16-bit-position instance and a
// 4-bit-position instance share all stimulus; only the wrap test reads the latter.
module tb_seq_match_monitor;

  logic       clk;
  logic       reset;
  logic       bit_valid;
  logic       det_in;
  logic       clear;
  logic [7:0] thresh;

  logic [7:0] match_count;
  logic       thresh_hit;
  logic       overflow;
  logic       state_dbg;

  logic [7:0] match_count4;
  logic       thresh_hit4;
  logic       overflow4;
  logic       state_dbg4;

  int checks;
  int errors;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  seq_match_monitor_if #(.POS_W(16)) pif ();
  seq_match_monitor_if #(.POS_W(4))  pif4 ();

  seq_match_monitor #(.CNT_W(8), .POS_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .det_in(det_in), .clear(clear),
    .thresh(thresh), .match_count(match_count), .thresh_hit(thresh_hit),
    .overflow(overflow), .state_dbg(state_dbg), .pos_if(pif.master)
  );

  seq_match_monitor #(.CNT_W(8), .POS_W(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .det_in(det_in), .clear(clear),
    .thresh(thresh), .match_count(match_count4), .thresh_hit(thresh_hit4),
    .overflow(overflow4), .state_dbg(state_dbg4), .pos_if(pif4.master)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs, then settle 1 ns past the edge
  task automatic step(input logic bv, input logic di, input logic rdy, input logic clr);
    bit_valid      = bv;
    det_in         = di;
    pif.pos_ready  = rdy;
    pif4.pos_ready = rdy;
    clear          = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d want 0", match_count); end
    checks++; if (thresh_hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b want 0", thresh_hit); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
    checks++; if (pif.pos_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", pif.pos_valid); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL rst_state got %b want 0", state_dbg); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL idle_count got %0d want 0", match_count); end
    checks++; if (pif.pos_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", pif.pos_valid); end
    // Position counter is now 5; the next event must record it
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (pif.pos_valid !== 1'b1) begin errors++; $display("FAIL pos5_valid got %b want 1", pif.pos_valid); end
    checks++; if (pif.pos_data !== 16'd5) begin errors++; $display("FAIL pos5_data got %0d want 5", pif.pos_data); end
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL pos5_count got %0d want 1", match_count); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (pif.pos_valid !== 1'b0) begin errors++; $display("FAIL pos5_pop got %b want 0", pif.pos_valid); end
  endtask

  task automatic test_threshold();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    thresh = 8'd2;
    for (int p = 0; p <= 10; p++) begin
      step(1'b1, (p == 3 || p == 7 || p == 10), 1'b0, 1'b0);
      if (p == 3) begin
        checks++; if (match_count !== 8'd1 || thresh_hit !== 1'b0) begin errors++; $display("FAIL thr_first got cnt=%0d hit=%b want cnt=1 hit=0", match_count, thresh_hit); end
      end
      if (p == 7) begin
        checks++; if (match_count !== 8'd2 || thresh_hit !== 1'b1) begin errors++; $display("FAIL thr_reach got cnt=%0d hit=%b want cnt=2 hit=1", match_count, thresh_hit); end
      end
      if (p == 10) begin
        checks++; if (match_count !== 8'd3 || thresh_hit !== 1'b1) begin errors++; $display("FAIL thr_sticky got cnt=%0d hit=%b want cnt=3 hit=1", match_count, thresh_hit); end
      end
    end
    thresh = 8'd50;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (pif.pos_data !== 16'd3 || thresh_hit !== 1'b1) begin errors++; $display("FAIL thr_hold got data=%0d hit=%b want data=3 hit=1", pif.pos_data, thresh_hit); end
    exp_q = '{16'd3, 16'd7, 16'd10};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++; if (pif.pos_valid !== 1'b1 || pif.pos_data !== exp_v) begin errors++; $display("FAIL thr_pop got v=%b d=%0d want v=1 d=%0d", pif.pos_valid, pif.pos_data, exp_v); end
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (pif.pos_valid !== 1'b0) begin errors++; $display("FAIL thr_empty got %b want 0", pif.pos_valid); end
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    thresh = 8'd0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (match_count !== 8'd6) begin errors++; $display("FAIL ovf_count got %0d want 6", match_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (thresh_hit !== 1'b0) begin errors++; $display("FAIL ovf_thr0 got %b want 0", thresh_hit); end
    exp_q = '{16'd0, 16'd1, 16'd2, 16'd3};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++; if (pif.pos_valid !== 1'b1 || pif.pos_data !== exp_v) begin errors++; $display("FAIL ovf_pop got v=%b d=%0d want v=1 d=%0d", pif.pos_valid, pif.pos_data, exp_v); end
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (pif.pos_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", pif.pos_valid); end
    // Threshold lowered below the count: no exact match, no hit
    thresh = 8'd3;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (match_count !== 8'd7 || thresh_hit !== 1'b0) begin errors++; $display("FAIL low_thr got cnt=%0d hit=%b want cnt=7 hit=0", match_count, thresh_hit); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_empty_push();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    thresh = 8'd0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (match_count !== 8'd0 || pif.pos_valid !== 1'b0) begin errors++; $display("FAIL no_bv got cnt=%0d v=%b want cnt=0 v=0", match_count, pif.pos_valid); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (pif.pos_valid !== 1'b1 || pif.pos_data !== 16'd0) begin errors++; $display("FAIL empty_push got v=%b d=%0d want v=1 d=0", pif.pos_valid, pif.pos_data); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (pif.pos_valid !== 1'b0) begin errors++; $display("FAIL empty_drain got %b want 0", pif.pos_valid); end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0 || pif.pos_valid !== 1'b1) begin errors++; $display("FAIL full_pre got ovf=%b v=%b want ovf=0 v=1", overflow, pif.pos_valid); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0 || match_count !== 8'd5) begin errors++; $display("FAIL full_pop got ovf=%b cnt=%0d want ovf=0 cnt=5", overflow, match_count); end
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++; if (pif.pos_valid !== 1'b1 || pif.pos_data !== exp_v) begin errors++; $display("FAIL full_pop_q got v=%b d=%0d want v=1 d=%0d", pif.pos_valid, pif.pos_data, exp_v); end
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (pif.pos_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", pif.pos_valid); end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    thresh = 8'd0;
    for (int i = 1; i <= 260; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 254) begin
        checks++; if (match_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", match_count); end
      end
    end
    checks++; if (match_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", match_count); end
    checks++; if (pif.pos_valid !== 1'b1 || pif.pos_data !== 16'd259) begin errors++; $display("FAIL sat_push got v=%b d=%0d want v=1 d=259", pif.pos_valid, pif.pos_data); end
  endtask

  task automatic test_pos_wrap();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (pif4.pos_valid !== 1'b1 || pif4.pos_data !== 4'd0) begin errors++; $display("FAIL wrap4 got v=%b d=%0d want v=1 d=0", pif4.pos_valid, pif4.pos_data); end
    checks++; if (pif.pos_data !== 16'd16) begin errors++; $display("FAIL wrap16 got %0d want 16", pif.pos_data); end
  endtask

  task automatic test_clear_in_hit();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    thresh = 8'd1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (thresh_hit !== 1'b1 || state_dbg !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL hit_pre got hit=%b st=%b ovf=%b want 1 1 1", thresh_hit, state_dbg, overflow); end
    thresh = 8'd9;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (thresh_hit !== 1'b1) begin errors++; $display("FAIL hit_thr_chg got %b want 1", thresh_hit); end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (match_count !== 8'd0 || thresh_hit !== 1'b0) begin errors++; $display("FAIL clr_cnt got cnt=%0d hit=%b want 0 0", match_count, thresh_hit); end
    checks++; if (overflow !== 1'b0 || pif.pos_valid !== 1'b0 || state_dbg !== 1'b0) begin errors++; $display("FAIL clr_flags got ovf=%b v=%b st=%b want 0 0 0", overflow, pif.pos_valid, state_dbg); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (pif.pos_data !== 16'd0 || match_count !== 8'd1 || thresh_hit !== 1'b0) begin errors++; $display("FAIL clr_after got d=%0d cnt=%0d hit=%b want 0 1 0", pif.pos_data, match_count, thresh_hit); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bit_valid      = 1'b0;
    det_in         = 1'b0;
    clear          = 1'b0;
    thresh         = 8'd0;
    pif.pos_ready  = 1'b0;
    pif4.pos_ready = 1'b0;
    test_reset();
    test_threshold();
    test_overflow();
    test_empty_push();
    test_back_to_back();
    test_saturate();
    test_pos_wrap();
    test_clear_in_hit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
